// File: rtl/arith_pkg.sv
// Shared types and constants for the exp2 arithmetic set.
package arith_pkg;

  localparam int DIV_W     = 4;
  localparam int DIV_CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/trial_subtractor5.sv
// Combinational trial subtraction of the divisor from the shifted partial remainder.
module trial_subtractor5
  import arith_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvs,
  output logic [W:0]   diff,
  output logic         neg
);

  // Difference in W+1 bits; the top bit doubles as the borrow flag
  always_comb begin
    diff = rem - {1'b0, dvs};
    neg  = diff[W];
  end

endmodule

// File: rtl/restoring_divider4bit.sv
// Sequential unsigned restoring divider: one shift/trial-subtract step per clock,
// start/done handshake, results only updated when a division completes.
module restoring_divider4bit
  import arith_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  div_state_t   state_r;
  logic [N:0]   r_r;
  logic [N-1:0] q_r;
  logic [N-1:0] d_r;
  logic [CW-1:0] cnt_r;

  logic [N:0]   shift_s;
  logic [N:0]   diff_s;
  logic         neg_s;
  logic [N:0]   r_next_s;
  logic [N-1:0] q_next_s;
  logic         accept_s;
  logic         zero_emit_s;

  trial_subtractor5 #(.W(N)) u_trial (
    .rem  (shift_s),
    .dvs  (d_r),
    .diff (diff_s),
    .neg  (neg_s)
  );

  // Next partial remainder/quotient for one iteration; restore on borrow
  always_comb begin
    shift_s  = (r_r << 1) | {{N{1'b0}}, q_r[N-1]};
    q_next_s = {q_r[N-2:0], ~neg_s};
    if (neg_s) begin
      r_next_s = shift_s;
    end else begin
      r_next_s = diff_s;
    end
    accept_s    = start && ((state_r == IDLE) || (state_r == DONE));
    zero_emit_s = (state_r == DONE) && (d_r == {N{1'b0}});
  end

  // FSM, iteration registers and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      r_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        RUN: begin
          r_r   <= r_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next_s;
            remainder   <= r_next_s[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          // A zero divisor skips RUN; its result is published on the way out of DONE
          if (zero_emit_s) begin
            done        <= 1'b1;
            quotient    <= {N{1'b1}};
            remainder   <= q_r;
            div_by_zero <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      if (accept_s) begin
        r_r   <= '0;
        q_r   <= dividend;
        d_r   <= divisor;
        cnt_r <= CW'(N);
        if (!zero_emit_s) begin
          div_by_zero <= 1'b0;
        end
        if (divisor == {N{1'b0}}) begin
          state_r <= DONE;
        end else begin
          state_r <= RUN;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule
